// File: rtl/spi_flash_frame_monitor.sv
// Passive single-I/O SPI flash bus monitor: oversamples C/S#/DQ0/DQ1 with the
// system clock and decodes each S#-framed transaction into opcode, address and
// data-byte events.
module spi_flash_frame_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_BYTES  = 3,
    parameter int DUMMY_CYC   = 8,
    parameter int CNT_W       = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    C,
    input  logic                    S,
    input  logic                    DQ0,
    input  logic                    DQ1,
    output logic                    op_valid,
    output logic [7:0]              opcode,
    output logic                    addr_valid,
    output logic [8*ADDR_BYTES-1:0] addr,
    output logic                    wr_valid,
    output logic                    rd_valid,
    output logic [7:0]              data_byte,
    output logic                    frame_done,
    output logic [CNT_W-1:0]        byte_cnt,
    output logic                    frame_err
);

    localparam int         AW         = 8 * ADDR_BYTES;
    localparam logic [2:0] ADDR_LAST  = 3'(ADDR_BYTES - 1);
    localparam logic [15:0] DUMMY_LAST = 16'(DUMMY_CYC - 1);

    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DUMMY, DATA} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] c_sync, s_sync, dq0_sync, dq1_sync, settle;
    logic                   c_prev, s_prev, armed;
    logic [2:0]             bit_cnt, bit_nxt;
    logic [2:0]             addr_cnt, addr_cnt_nxt;
    logic [15:0]            dummy_cnt, dummy_nxt;
    logic [7:0]             shift, shift_nxt, new_byte, opcode_nxt, data_nxt;
    logic [AW-1:0]          addr_sh, addr_sh_nxt, addr_nxt;
    logic [CNT_W-1:0]       byte_cnt_nxt;
    logic                   rd_mode, rd_nxt, dq_bit;
    logic                   c_s, s_s, dq0_s, dq1_s, settled;
    logic                   cr, s_rise, start;
    logic                   op_p, addr_p, wr_p, rd_p, done_p, err_p;

    assign c_s     = c_sync[SYNC_STAGES-1];
    assign s_s     = s_sync[SYNC_STAGES-1];
    assign dq0_s   = dq0_sync[SYNC_STAGES-1];
    assign dq1_s   = dq1_sync[SYNC_STAGES-1];
    assign settled = settle[SYNC_STAGES-1];
    assign cr      = c_s & ~c_prev;
    assign s_rise  = s_s & ~s_prev;
    // A frame only starts once S has been seen high after reset, so a transfer
    // already running when reset is released is skipped entirely.
    assign start   = ~s_s & s_prev & armed;

    // Input synchronizers, edge-detect history and the post-reset arming flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c_sync   <= '0;
            s_sync   <= '1;
            dq0_sync <= '0;
            dq1_sync <= '0;
            settle   <= '0;
            c_prev   <= 1'b0;
            s_prev   <= 1'b1;
            armed    <= 1'b0;
        end else begin
            c_sync   <= {c_sync[SYNC_STAGES-2:0], C};
            s_sync   <= {s_sync[SYNC_STAGES-2:0], S};
            dq0_sync <= {dq0_sync[SYNC_STAGES-2:0], DQ0};
            dq1_sync <= {dq1_sync[SYNC_STAGES-2:0], DQ1};
            settle   <= {settle[SYNC_STAGES-2:0], 1'b1};
            c_prev   <= c_s;
            s_prev   <= s_s;
            armed    <= armed | (settled & s_s);
        end
    end

    // Next-state decode: shift bits on each C rise, emit field/byte events and
    // close the frame on S rise (a byte completing in that same cycle still counts).
    always_comb begin
        state_nxt    = state;
        bit_nxt      = bit_cnt;
        addr_cnt_nxt = addr_cnt;
        dummy_nxt    = dummy_cnt;
        shift_nxt    = shift;
        addr_sh_nxt  = addr_sh;
        addr_nxt     = addr;
        opcode_nxt   = opcode;
        data_nxt     = data_byte;
        byte_cnt_nxt = byte_cnt;
        rd_nxt       = rd_mode;
        op_p         = 1'b0;
        addr_p       = 1'b0;
        wr_p         = 1'b0;
        rd_p         = 1'b0;
        done_p       = 1'b0;
        err_p        = 1'b0;
        dq_bit       = (state == DATA && rd_mode) ? dq1_s : dq0_s;
        new_byte     = {shift[6:0], dq_bit};

        if (state == IDLE) begin
            if (start) begin
                state_nxt    = OPCODE;
                bit_nxt      = '0;
                addr_cnt_nxt = '0;
                dummy_nxt    = '0;
                shift_nxt    = '0;
                addr_sh_nxt  = '0;
                addr_nxt     = '0;
                byte_cnt_nxt = '0;
                rd_nxt       = 1'b0;
            end
        end else begin
            if (cr) begin
                if (state == DUMMY) begin
                    if (dummy_cnt == DUMMY_LAST) begin
                        dummy_nxt = '0;
                        state_nxt = DATA;
                        rd_nxt    = 1'b1;
                    end else begin
                        dummy_nxt = dummy_cnt + 16'd1;
                    end
                end else begin
                    shift_nxt = new_byte;
                    bit_nxt   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            OPCODE: begin
                                op_p       = 1'b1;
                                opcode_nxt = new_byte;
                                case (new_byte)
                                    8'h03, 8'h0B, 8'h02, 8'hD8, 8'h20: state_nxt = ADDR;
                                    8'h9F, 8'h05: begin
                                        state_nxt = DATA;
                                        rd_nxt    = 1'b1;
                                    end
                                    default: begin
                                        state_nxt = DATA;
                                        rd_nxt    = 1'b0;
                                    end
                                endcase
                            end
                            ADDR: begin
                                addr_sh_nxt = {addr_sh[AW-9:0], new_byte};
                                if (addr_cnt == ADDR_LAST) begin
                                    addr_cnt_nxt = '0;
                                    addr_p       = 1'b1;
                                    addr_nxt     = addr_sh_nxt;
                                    state_nxt    = DATA;
                                    if (opcode == 8'h0B) begin
                                        rd_nxt = 1'b1;
                                        if (DUMMY_CYC != 0) state_nxt = DUMMY;
                                    end else begin
                                        rd_nxt = (opcode == 8'h03);
                                    end
                                end else begin
                                    addr_cnt_nxt = addr_cnt + 3'd1;
                                end
                            end
                            default: begin
                                data_nxt = new_byte;
                                rd_p     = rd_mode;
                                wr_p     = ~rd_mode;
                                if (byte_cnt != '1) byte_cnt_nxt = byte_cnt + 1'b1;
                            end
                        endcase
                    end
                end
            end
            if (s_rise) begin
                done_p    = 1'b1;
                err_p     = (bit_nxt != 3'd0) ||
                            (state_nxt == ADDR && addr_cnt_nxt != 3'd0) ||
                            (state_nxt == DUMMY && dummy_nxt != 16'd0);
                state_nxt = IDLE;
            end
        end
    end

    // Frame state, field counters and the registered event/held outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            addr_cnt   <= '0;
            dummy_cnt  <= '0;
            shift      <= '0;
            addr_sh    <= '0;
            rd_mode    <= 1'b0;
            op_valid   <= 1'b0;
            opcode     <= '0;
            addr_valid <= 1'b0;
            addr       <= '0;
            wr_valid   <= 1'b0;
            rd_valid   <= 1'b0;
            data_byte  <= '0;
            frame_done <= 1'b0;
            byte_cnt   <= '0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_nxt;
            addr_cnt   <= addr_cnt_nxt;
            dummy_cnt  <= dummy_nxt;
            shift      <= shift_nxt;
            addr_sh    <= addr_sh_nxt;
            rd_mode    <= rd_nxt;
            op_valid   <= op_p;
            opcode     <= opcode_nxt;
            addr_valid <= addr_p;
            addr       <= addr_nxt;
            wr_valid   <= wr_p;
            rd_valid   <= rd_p;
            data_byte  <= data_nxt;
            frame_done <= done_p;
            byte_cnt   <= byte_cnt_nxt;
            frame_err  <= err_p;
        end
    end

endmodule

// File: tb/tb_spi_flash_frame_monitor.sv
// Directed bench for spi_flash_frame_monitor: drives mode-0 SPI frames and
// compares the decoded event stream against hand-computed values.
module tb_spi_flash_frame_monitor;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        C = 1'b0;
    logic        S = 1'b1;
    logic        DQ0 = 1'b0;
    logic        DQ1 = 1'b0;
    logic        op_valid, addr_valid, wr_valid, rd_valid, frame_done, frame_err;
    logic [7:0]  opcode, data_byte;
    logic [23:0] addr;
    logic [15:0] byte_cnt;

    int checks = 0;
    int errors = 0;

    int op_seen = 0, addr_seen = 0, done_seen = 0, err_seen = 0;
    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];

    int op0, addr0, done0, err0, wr0, rd0;

    spi_flash_frame_monitor dut (
        .clock(clock), .reset_n(reset_n), .C(C), .S(S), .DQ0(DQ0), .DQ1(DQ1),
        .op_valid(op_valid), .opcode(opcode), .addr_valid(addr_valid), .addr(addr),
        .wr_valid(wr_valid), .rd_valid(rd_valid), .data_byte(data_byte),
        .frame_done(frame_done), .byte_cnt(byte_cnt), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    // Collect event pulses away from the active edge.
    always @(negedge clock) begin
        if (op_valid)   op_seen++;
        if (addr_valid) addr_seen++;
        if (frame_done) done_seen++;
        if (frame_err)  err_seen++;
        if (wr_valid)   wr_q.push_back(data_byte);
        if (rd_valid)   rd_q.push_back(data_byte);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snapshot();
        op0 = op_seen; addr0 = addr_seen; done0 = done_seen; err0 = err_seen;
        wr0 = wr_q.size(); rd0 = rd_q.size();
    endtask

    // Drive nbits MSB-first (C period = 8 system clocks); optionally end the frame.
    task automatic applyStimulus(input int nbits, input logic [63:0] mosi,
                                 input logic [63:0] miso, input bit finish_frame);
        S = 1'b0;
        #40;
        for (int i = nbits - 1; i >= 0; i--) begin
            DQ0 = mosi[i];
            DQ1 = miso[i];
            #40 C = 1'b1;
            #40 C = 1'b0;
        end
        if (finish_frame) begin
            #40 S = 1'b1;
            #200;
        end
    endtask

    initial begin
        #23;
        checkOutput("reset_opcode", {24'h0, opcode}, 32'h0);
        checkOutput("reset_flags", {26'h0, op_valid, addr_valid, wr_valid, rd_valid, frame_done, frame_err}, 32'h0);
        checkOutput("reset_cnt", {16'h0, byte_cnt}, 32'h0);
        reset_n = 1'b1;
        #100;

        // WREN: opcode only
        snapshot();
        applyStimulus(8, 64'h06, 64'h0, 1'b1);
        checkOutput("wren_op_cnt", op_seen - op0, 1);
        checkOutput("wren_opcode", {24'h0, opcode}, 32'h06);
        checkOutput("wren_done", done_seen - done0, 1);
        checkOutput("wren_err", err_seen - err0, 0);
        checkOutput("wren_bytes", {16'h0, byte_cnt}, 32'd0);

        // Page program with two write bytes
        snapshot();
        applyStimulus(48, {16'h0, 8'h02, 24'h012345, 8'hA5, 8'h5A}, 64'h0, 1'b1);
        checkOutput("pp_opcode", {24'h0, opcode}, 32'h02);
        checkOutput("pp_addr_cnt", addr_seen - addr0, 1);
        checkOutput("pp_addr", {8'h0, addr}, 32'h012345);
        checkOutput("pp_wr_cnt", wr_q.size() - wr0, 2);
        checkOutput("pp_rd_cnt", rd_q.size() - rd0, 0);
        if (wr_q.size() >= wr0 + 2) begin
            checkOutput("pp_wr0", {24'h0, wr_q[wr0]}, 32'hA5);
            checkOutput("pp_wr1", {24'h0, wr_q[wr0+1]}, 32'h5A);
        end
        checkOutput("pp_bytes", {16'h0, byte_cnt}, 32'd2);
        checkOutput("pp_err", err_seen - err0, 0);

        // FAST_READ with dummy byte driving FF on DQ1
        snapshot();
        applyStimulus(56, {8'h0, 8'h0B, 24'h000100, 24'h0},
                      {8'h0, 32'h0, 8'hFF, 8'h3C, 8'hC3}, 1'b1);
        checkOutput("fr_addr", {8'h0, addr}, 32'h000100);
        checkOutput("fr_rd_cnt", rd_q.size() - rd0, 2);
        if (rd_q.size() >= rd0 + 2) begin
            checkOutput("fr_rd0", {24'h0, rd_q[rd0]}, 32'h3C);
            checkOutput("fr_rd1", {24'h0, rd_q[rd0+1]}, 32'hC3);
        end
        checkOutput("fr_wr_cnt", wr_q.size() - wr0, 0);
        checkOutput("fr_bytes", {16'h0, byte_cnt}, 32'd2);

        // RDID: three read bytes, no address
        snapshot();
        applyStimulus(32, {32'h0, 8'h9F, 24'h0}, {32'h0, 8'h0, 24'h20BA17}, 1'b1);
        checkOutput("rdid_addr_cnt", addr_seen - addr0, 0);
        checkOutput("rdid_rd_cnt", rd_q.size() - rd0, 3);
        if (rd_q.size() >= rd0 + 3) begin
            checkOutput("rdid_rd0", {24'h0, rd_q[rd0]}, 32'h20);
            checkOutput("rdid_rd1", {24'h0, rd_q[rd0+1]}, 32'hBA);
            checkOutput("rdid_rd2", {24'h0, rd_q[rd0+2]}, 32'h17);
        end
        checkOutput("rdid_bytes", {16'h0, byte_cnt}, 32'd3);

        // READ aborted after 12 address bits
        snapshot();
        applyStimulus(20, 64'h03012, 64'h0, 1'b1);
        checkOutput("abort_op_cnt", op_seen - op0, 1);
        checkOutput("abort_addr_cnt", addr_seen - addr0, 0);
        checkOutput("abort_done", done_seen - done0, 1);
        checkOutput("abort_err", err_seen - err0, 1);

        // Reset mid-DATA of a PP, then a clean RDSR frame
        snapshot();
        applyStimulus(36, {28'h0, 8'h02, 24'h000000, 4'hA}, 64'h0, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_opcode", {24'h0, opcode}, 32'h0);
        checkOutput("rst_cnt", {16'h0, byte_cnt}, 32'h0);
        checkOutput("rst_addr", {8'h0, addr}, 32'h0);
        #20 reset_n = 1'b1;
        applyStimulus(8, 64'hFF, 64'h0, 1'b1);
        checkOutput("rst_no_done", done_seen - done0, 0);
        snapshot();
        applyStimulus(16, {48'h0, 8'h05, 8'h00}, {48'h0, 8'h00, 8'h80}, 1'b1);
        checkOutput("rdsr_opcode", {24'h0, opcode}, 32'h05);
        checkOutput("rdsr_rd_cnt", rd_q.size() - rd0, 1);
        if (rd_q.size() >= rd0 + 1)
            checkOutput("rdsr_rd0", {24'h0, rd_q[rd0]}, 32'h80);
        checkOutput("rdsr_done", done_seen - done0, 1);
        checkOutput("rdsr_bytes", {16'h0, byte_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
